// File: rtl/regfile_2w2r_sb.sv
// Two-write/two-read register file with a pending scoreboard and a post-reset clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_2w2r_sb #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   ADR1,
    input  logic [AW-1:0]   ADR2,
    output logic [XLEN-1:0] RS1,
    output logic [XLEN-1:0] RS2,
    output logic            RS1_PEND,
    output logic            RS2_PEND,
    input  logic            WE0,
    input  logic [AW-1:0]   WA0,
    input  logic [XLEN-1:0] WD0,
    input  logic            WE1,
    input  logic [AW-1:0]   WA1,
    input  logic [XLEN-1:0] WD1,
    input  logic            SB_SET,
    input  logic [AW-1:0]   SB_ADR,
    output logic            READY
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   mem_q [NREGS];
    logic [XLEN-1:0]   mem_d [NREGS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_RUN: begin
                // Set is applied after clear so a newly issued producer wins.
                if (WE0) pend_d[WA0] = 1'b0;
                if (WE1) pend_d[WA1] = 1'b0;
                if (SB_SET) pend_d[SB_ADR] = 1'b1;
            end
            default: state_d = S_CLEAR;
        endcase
        pend_d[0] = 1'b0;
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == S_CLEAR) begin
            mem_d[cnt_q] = '0;
        end else begin
            if (WE0) mem_d[WA0] = WD0;
            if (WE1) mem_d[WA1] = WD1;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_CLEAR;
            cnt_q   <= AW'(1);
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // The clear sweep initialises the array, so it carries no reset.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0]   adr;
        logic [XLEN-1:0] data;
        logic            pend;

        assign adr = (p == 0) ? ADR1 : ADR2;

        always_comb begin
            data = '0;
            pend = 1'b0;
            if (state_q == S_RUN && adr != '0) begin
                data = mem_q[adr];
                pend = pend_q[adr];
`ifdef REGFILE_BYPASS_EN
                if (WE1 && WA1 == adr) begin
                    data = WD1;
                    pend = 1'b0;
                end else if (WE0 && WA0 == adr) begin
                    data = WD0;
                    pend = 1'b0;
                end
`endif
            end
        end
    end

    assign RS1      = g_rd[0].data;
    assign RS2      = g_rd[1].data;
    assign RS1_PEND = g_rd[0].pend;
    assign RS2_PEND = g_rd[1].pend;
    assign READY    = (state_q == S_RUN);

endmodule
